// File: rtl/fb_arbiter_pkg.sv
// Shared types and default widths for the frame-buffer arbiter.
package fb_arbiter_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned BE_W            = 4;
  localparam int unsigned DEF_ADDR_W      = 30;
  localparam int unsigned DEF_MAX_PENDING = 8;
  localparam int unsigned DEF_CPU_EVERY   = 4;

  typedef enum logic {
    MASTER_VIDEO = 1'b0,
    MASTER_CPU   = 1'b1
  } master_id_t;

endpackage

// File: rtl/fb_tag_fifo.sv
// Owner-ID FIFO: one entry per outstanding read, popped as beats return in order.
module fb_tag_fifo
  import fb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_MAX_PENDING
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  master_id_t               push_id_i,
  input  logic                     pop_i,
  output master_id_t               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  master_id_t         mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Two-master arbiter sharing one pipelined frame-buffer slave between video DMA and CPU,
// with in-order routing of read beats back to their issuer.
module fb_arbiter
  import fb_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned MAX_PENDING = DEF_MAX_PENDING,
  parameter int unsigned CPU_EVERY   = DEF_CPU_EVERY
) (
  input  logic                memory_clock,
  input  logic                reset_n,

  input  logic [ADDR_W-1:0]   video_address,
  input  logic                video_read,
  output logic                video_waitrequest,
  output logic [DATA_W-1:0]   video_readdata,
  output logic                video_readdatavalid,

  input  logic [ADDR_W-1:0]   cpu_address,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [DATA_W-1:0]   cpu_writedata,
  input  logic [BE_W-1:0]     cpu_byteenable,
  output logic                cpu_waitrequest,
  output logic [DATA_W-1:0]   cpu_readdata,
  output logic                cpu_readdatavalid,

  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [BE_W-1:0]     mem_byteenable,
  input  logic                mem_waitrequest,
  input  logic [DATA_W-1:0]   mem_readdata,
  input  logic                mem_readdatavalid,

  output logic                err_orphan
);

  localparam int unsigned CNT_W    = $clog2(MAX_PENDING) + 1;
  localparam int unsigned STREAK_W = $clog2(CPU_EVERY + 1);

  logic                locked_q, locked_d;
  master_id_t          lock_owner_q, lock_owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                err_orphan_q, err_orphan_d;

  logic                fifo_full, fifo_empty;
  master_id_t          fifo_head;
  logic [CNT_W-1:0]    fifo_count;

  logic                cpu_req, vid_eff, cpu_eff;
  logic                grant_vld;
  master_id_t          grant_id;
  logic                cmd_vld, accept, push;

  // A read that cannot get a tag is not a candidate, so a full FIFO never blocks CPU writes.
  assign cpu_req = cpu_read | cpu_write;
  assign vid_eff = video_read & ~fifo_full;
  assign cpu_eff = cpu_write | (cpu_read & ~fifo_full);

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = MASTER_VIDEO;
    if (locked_q) begin
      grant_vld = 1'b1;
      grant_id  = lock_owner_q;
    end else if (vid_eff && !(cpu_eff && streak_q == STREAK_W'(CPU_EVERY))) begin
      grant_vld = 1'b1;
      grant_id  = MASTER_VIDEO;
    end else if (cpu_eff) begin
      grant_vld = 1'b1;
      grant_id  = MASTER_CPU;
    end
  end

  always_comb begin
    mem_address    = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    if (grant_vld) begin
      if (grant_id == MASTER_CPU) begin
        mem_address    = cpu_address;
        mem_read       = cpu_read & ~fifo_full;
        mem_write      = cpu_write;
        mem_writedata  = cpu_writedata;
        mem_byteenable = cpu_byteenable;
      end else begin
        mem_address    = video_address;
        mem_read       = video_read & ~fifo_full;
        mem_byteenable = 4'hF;
      end
    end
  end

  assign cmd_vld = mem_read | mem_write;
  assign accept  = cmd_vld & ~mem_waitrequest;
  assign push    = mem_read & ~mem_waitrequest;

  assign video_waitrequest = (grant_vld && grant_id == MASTER_VIDEO)
                             ? (mem_waitrequest | fifo_full) : 1'b1;
  assign cpu_waitrequest   = (grant_vld && grant_id == MASTER_CPU)
                             ? (mem_waitrequest | (cpu_read & fifo_full)) : 1'b1;

  assign video_readdata      = mem_readdata;
  assign cpu_readdata        = mem_readdata;
  assign video_readdatavalid = mem_readdatavalid & ~fifo_empty & (fifo_head == MASTER_VIDEO);
  assign cpu_readdatavalid   = mem_readdatavalid & ~fifo_empty & (fifo_head == MASTER_CPU);
  assign err_orphan          = err_orphan_q;

  // Lock holds a stalled request on the bus until the slave takes it.
  always_comb begin
    locked_d     = cmd_vld & mem_waitrequest;
    lock_owner_d = lock_owner_q;
    streak_d     = streak_q;
    err_orphan_d = err_orphan_q;
    if (cmd_vld && mem_waitrequest) lock_owner_d = grant_id;
    if (!cpu_req || (accept && grant_id == MASTER_CPU)) begin
      streak_d = '0;
    end else if (accept && grant_id == MASTER_VIDEO && streak_q != STREAK_W'(CPU_EVERY)) begin
      streak_d = streak_q + STREAK_W'(1);
    end
    if (mem_readdatavalid && fifo_empty) err_orphan_d = 1'b1;
  end

  always_ff @(posedge memory_clock or negedge reset_n) begin
    if (!reset_n) begin
      locked_q     <= 1'b0;
      lock_owner_q <= MASTER_VIDEO;
      streak_q     <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      locked_q     <= locked_d;
      lock_owner_q <= lock_owner_d;
      streak_q     <= streak_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  always_ff @(posedge memory_clock) begin
    if (reset_n) assert (fifo_count <= CNT_W'(MAX_PENDING));
  end

  fb_tag_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_tag_fifo (
    .clk_i     (memory_clock),
    .rst_ni    (reset_n),
    .push_i    (push),
    .push_id_i (grant_id),
    .pop_i     (mem_readdatavalid),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: fixed-latency slave model plus hand-computed grant/route expectations.
module tb_fb_arbiter;

  logic        clk;
  logic        reset_n;
  logic [29:0] video_address;
  logic        video_read;
  logic        video_waitrequest;
  logic [31:0] video_readdata;
  logic        video_readdatavalid;
  logic [29:0] cpu_address;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic        cpu_readdatavalid;
  logic [29:0] mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;
  logic        err_orphan;

  fb_arbiter #(.ADDR_W(30), .MAX_PENDING(8), .CPU_EVERY(4)) dut (
    .memory_clock        (clk),
    .reset_n             (reset_n),
    .video_address       (video_address),
    .video_read          (video_read),
    .video_waitrequest   (video_waitrequest),
    .video_readdata      (video_readdata),
    .video_readdatavalid (video_readdatavalid),
    .cpu_address         (cpu_address),
    .cpu_read            (cpu_read),
    .cpu_write           (cpu_write),
    .cpu_writedata       (cpu_writedata),
    .cpu_byteenable      (cpu_byteenable),
    .cpu_waitrequest     (cpu_waitrequest),
    .cpu_readdata        (cpu_readdata),
    .cpu_readdatavalid   (cpu_readdatavalid),
    .mem_address         (mem_address),
    .mem_read            (mem_read),
    .mem_write           (mem_write),
    .mem_writedata       (mem_writedata),
    .mem_byteenable      (mem_byteenable),
    .mem_waitrequest     (mem_waitrequest),
    .mem_readdata        (mem_readdata),
    .mem_readdatavalid   (mem_readdatavalid),
    .err_orphan          (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } beat_t;

  beat_t       rq[$];
  logic [31:0] dq[$];
  logic [31:0] vgot[$];
  logic [31:0] cgot[$];
  int unsigned cyc;
  int unsigned lat;
  int          n_cmp;
  int          n_bad;

  function automatic logic [31:0] beat_data(input logic [29:0] a);
    return 32'hD000_0000 | 32'(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Negedge: record accepted reads into the slave queue and collect routed beats.
  task automatic sample();
    beat_t b;
    @(negedge clk);
    if (mem_read && !mem_waitrequest) begin
      b.due  = cyc + lat;
      b.data = beat_data(mem_address);
      if (dq.size() != 0) b.data = dq.pop_front();
      rq.push_back(b);
    end
    if (video_readdatavalid) vgot.push_back(video_readdata);
    if (cpu_readdatavalid)   cgot.push_back(cpu_readdata);
  endtask

  // Just after posedge: advance cycle and present at most one due beat.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mem_readdatavalid = 1'b0;
    mem_readdata      = '0;
    if (rq.size() != 0 && rq[0].due <= cyc) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = rq[0].data;
      void'(rq.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      sample();
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [29:0] exp1 [0:9];
    logic [29:0] va, ca;
    exp1 = '{30'h100, 30'h101, 30'h102, 30'h103, 30'h200,
             30'h104, 30'h105, 30'h106, 30'h107, 30'h201};
    n_cmp = 0; n_bad = 0; cyc = 0; lat = 2;
    reset_n = 1'b0;
    video_address = '0; video_read = 1'b0;
    cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_writedata = '0; cpu_byteenable = '0;
    mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdatavalid = 1'b0;

    // Reset state
    sample();
    check("rst_mem_read",  32'(mem_read),            32'd0);
    check("rst_mem_write", 32'(mem_write),           32'd0);
    check("rst_vvalid",    32'(video_readdatavalid), 32'd0);
    check("rst_cvalid",    32'(cpu_readdatavalid),   32'd0);
    check("rst_orphan",    32'(err_orphan),          32'd0);
    tick();
    reset_n = 1'b1;
    idle(2);

    // Both masters streaming reads: V V V V C V V V V C
    lat = 2; vgot.delete(); cgot.delete();
    va = 30'h100; ca = 30'h200;
    video_read = 1'b1; cpu_read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      video_address = va; cpu_address = ca;
      sample();
      check($sformatf("t1_addr%0d", i), 32'(mem_address), 32'(exp1[i]));
      check($sformatf("t1_rd%0d", i),   32'(mem_read),    32'd1);
      if (video_read && !video_waitrequest) va++;
      if (cpu_read && !cpu_waitrequest) ca++;
      tick();
    end
    video_read = 1'b0; cpu_read = 1'b0;
    idle(6);
    check("t1_vcount", 32'(vgot.size()), 32'd8);
    check("t1_ccount", 32'(cgot.size()), 32'd2);
    for (int i = 0; i < 8; i++)
      check($sformatf("t1_vdata%0d", i), (i < vgot.size()) ? vgot[i] : 32'hDEAD_DEAD,
            beat_data(30'h100 + 30'(i)));
    for (int i = 0; i < 2; i++)
      check($sformatf("t1_cdata%0d", i), (i < cgot.size()) ? cgot[i] : 32'hDEAD_DEAD,
            beat_data(30'h200 + 30'(i)));

    // Video read held by waitrequest for 3 cycles while CPU raises a write
    vgot.delete(); cgot.delete();
    video_read = 1'b1; video_address = 30'h300; mem_waitrequest = 1'b1;
    sample();
    check("t2_addr0",  32'(mem_address),       32'h300);
    check("t2_vwait0", 32'(video_waitrequest), 32'd1);
    tick();
    cpu_write = 1'b1; cpu_address = 30'h400;
    cpu_writedata = 32'hCAFE_BABE; cpu_byteenable = 4'h3;
    for (int i = 1; i < 3; i++) begin
      sample();
      check($sformatf("t2_addr%0d", i),  32'(mem_address),     32'h300);
      check($sformatf("t2_wr%0d", i),    32'(mem_write),       32'd0);
      check($sformatf("t2_cwait%0d", i), 32'(cpu_waitrequest), 32'd1);
      tick();
    end
    mem_waitrequest = 1'b0;
    sample();
    check("t2_addr3",  32'(mem_address),       32'h300);
    check("t2_rd3",    32'(mem_read),          32'd1);
    check("t2_vwait3", 32'(video_waitrequest), 32'd0);
    tick();
    video_read = 1'b0;
    sample();
    check("t2_cwr",    32'(mem_write),       32'd1);
    check("t2_caddr",  32'(mem_address),     32'h400);
    check("t2_cwdata", mem_writedata,        32'hCAFE_BABE);
    check("t2_cbe",    32'(mem_byteenable),  32'h3);
    check("t2_cwait",  32'(cpu_waitrequest), 32'd0);
    tick();
    // CPU write stalled holds the bus against a newly arriving video read
    cpu_address = 30'h401; mem_waitrequest = 1'b1;
    sample();
    check("t2_lk_wr0", 32'(mem_write), 32'd1);
    tick();
    video_read = 1'b1; video_address = 30'h301;
    sample();
    check("t2_lk_rd",    32'(mem_read),          32'd0);
    check("t2_lk_addr",  32'(mem_address),       32'h401);
    check("t2_lk_vwait", 32'(video_waitrequest), 32'd1);
    tick();
    mem_waitrequest = 1'b0;
    sample();
    check("t2_lk_addr2", 32'(mem_address),     32'h401);
    check("t2_lk_cwait", 32'(cpu_waitrequest), 32'd0);
    tick();
    cpu_write = 1'b0;
    sample();
    check("t2_v2_addr",  32'(mem_address),       32'h301);
    check("t2_v2_vwait", 32'(video_waitrequest), 32'd0);
    tick();
    video_read = 1'b0;
    idle(5);
    check("t2_vcount", 32'(vgot.size()), 32'd2);
    check("t2_ccount", 32'(cgot.size()), 32'd0);
    check("t2_vdata0", (vgot.size() > 0) ? vgot[0] : 32'hDEAD_DEAD, beat_data(30'h300));
    check("t2_vdata1", (vgot.size() > 1) ? vgot[1] : 32'hDEAD_DEAD, beat_data(30'h301));

    // Latency-10 slave: 8 reads fill the tag FIFO, stall until first beat; CPU write passes
    lat = 10; vgot.delete(); cgot.delete();
    va = 30'h500; video_read = 1'b1;
    for (int t = 0; t < 12; t++) begin
      video_address = va;
      cpu_write     = (t == 9);
      cpu_address   = 30'h600;
      sample();
      check($sformatf("t3_vwait%0d", t), 32'(video_waitrequest), 32'((t >= 8) && (t <= 10)));
      if (t == 8) check("t3_rd_suppressed", 32'(mem_read), 32'd0);
      if (t == 9) begin
        check("t3_cpu_wr",    32'(mem_write),       32'd1);
        check("t3_cpu_addr",  32'(mem_address),     32'h600);
        check("t3_cpu_wait",  32'(cpu_waitrequest), 32'd0);
      end
      if (video_read && !video_waitrequest) va++;
      tick();
    end
    video_read = 1'b0; cpu_write = 1'b0;
    idle(14);
    check("t3_vcount", 32'(vgot.size()), 32'd9);
    for (int i = 0; i < 9; i++)
      check($sformatf("t3_vdata%0d", i), (i < vgot.size()) ? vgot[i] : 32'hDEAD_DEAD,
            beat_data(30'h500 + 30'(i)));

    // Interleaved V,C,V,C reads with fixed return data
    lat = 3; vgot.delete(); cgot.delete();
    dq = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      video_read = ((i % 2) == 0); cpu_read = ((i % 2) == 1);
      video_address = 30'h10 + 30'(i); cpu_address = 30'h20 + 30'(i);
      sample();
      tick();
    end
    video_read = 1'b0; cpu_read = 1'b0;
    idle(6);
    check("t4_vcount", 32'(vgot.size()), 32'd2);
    check("t4_ccount", 32'(cgot.size()), 32'd2);
    check("t4_v0", (vgot.size() > 0) ? vgot[0] : 32'hDEAD_DEAD, 32'h11);
    check("t4_v1", (vgot.size() > 1) ? vgot[1] : 32'hDEAD_DEAD, 32'h33);
    check("t4_c0", (cgot.size() > 0) ? cgot[0] : 32'hDEAD_DEAD, 32'h22);
    check("t4_c1", (cgot.size() > 1) ? cgot[1] : 32'hDEAD_DEAD, 32'h44);

    // Orphan beat with nothing outstanding
    check("t5_orphan_pre", 32'(err_orphan), 32'd0);
    mem_readdatavalid = 1'b1; mem_readdata = 32'h99;
    sample();
    check("t5_vvalid", 32'(video_readdatavalid), 32'd0);
    check("t5_cvalid", 32'(cpu_readdatavalid),   32'd0);
    tick();
    sample();
    check("t5_orphan_set", 32'(err_orphan), 32'd1);
    tick();
    idle(3);
    sample();
    check("t5_orphan_sticky", 32'(err_orphan), 32'd1);
    tick();

    // Reset with 3 reads pending: late beats are orphans, new reads route correctly
    lat = 10; vgot.delete(); cgot.delete();
    video_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      video_address = 30'h700 + 30'(i);
      sample();
      tick();
    end
    video_read = 1'b0;
    reset_n = 1'b0;
    sample();
    check("t6_rst_orphan", 32'(err_orphan),          32'd0);
    check("t6_rst_vvalid", 32'(video_readdatavalid), 32'd0);
    check("t6_rst_cvalid", 32'(cpu_readdatavalid),   32'd0);
    tick();
    reset_n = 1'b1;
    idle(14);
    check("t6_late_orphan", 32'(err_orphan),   32'd1);
    check("t6_late_vcount", 32'(vgot.size()),  32'd0);
    check("t6_late_ccount", 32'(cgot.size()),  32'd0);
    lat = 2;
    video_read = 1'b1; video_address = 30'h720;
    sample();
    tick();
    video_read = 1'b0; cpu_read = 1'b1; cpu_address = 30'h820;
    sample();
    tick();
    cpu_read = 1'b0;
    idle(5);
    check("t6_vcount", 32'(vgot.size()), 32'd1);
    check("t6_ccount", 32'(cgot.size()), 32'd1);
    check("t6_vdata", (vgot.size() > 0) ? vgot[0] : 32'hDEAD_DEAD, beat_data(30'h720));
    check("t6_cdata", (cgot.size() > 0) ? cgot[0] : 32'hDEAD_DEAD, beat_data(30'h820));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
